// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the extended input PIO: the register map and the
// power-on values of the edge-enable registers.
package soc_system_pio_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_LEVEL    = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_DB_LIMIT = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd7;

  // Any-edge capture out of reset
  localparam logic [31:0] RISE_EN_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] FALL_EN_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/soc_system_pio_db_bit.sv
// One input bit: synchroniser chain, debounce counter, stable value and its
// one-cycle-delayed copy used for edge detection.
module soc_system_pio_db_bit #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_bit,
  input  logic [DB_CNT_W-1:0] db_limit,
  output logic                stable,
  output logic                rise,
  output logic                fall,
  output logic                raw
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_CNT_W-1:0]    cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   prev_q, prev_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], in_bit};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    // A lowered limit commits on the next mismatch once the count already reaches it
    if (db_limit == '0) begin
      stable_d = sync;
      cnt_d    = '0;
    end else if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= db_limit - DB_CNT_W'(1)) begin
      stable_d = sync;
      cnt_d    = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + DB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_q & ~prev_q;
  assign fall   = ~stable_q & prev_q;
  assign raw    = sync;

endmodule

// File: rtl/soc_system_pio_in_ext.sv
// Avalon-MM input PIO with per-bit debounce, edge selection, W1C edge capture
// and level/edge interrupt sources.
module soc_system_pio_in_ext
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [WIDTH-1:0]  in_port
);

  logic [WIDTH-1:0]    stable, rise, fall, raw;
  logic [WIDTH-1:0]    rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [WIDTH-1:0]    mask_q, mask_d, cap_q, cap_d, level_q, level_d;
  logic [DB_CNT_W-1:0] db_limit_q, db_limit_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [WIDTH-1:0]    wdata_w, set_w, clr_w;
  logic                wr_en;
  logic                unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_pio_db_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CNT_W   (DB_CNT_W)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .in_bit  (in_port[i]),
      .db_limit(db_limit_q),
      .stable  (stable[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .raw     (raw[i])
    );
  end

  always_comb begin
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    mask_d     = mask_q;
    level_d    = level_q;
    db_limit_d = db_limit_q;
    readdata_d = '0;
    wr_en      = chipselect & ~write_n;
    wdata_w    = writedata[WIDTH-1:0];

    if (wr_en) begin
      case (address)
        ADDR_RISE_EN:  rise_en_d  = wdata_w;
        ADDR_IRQ_MASK: mask_d     = wdata_w;
        ADDR_FALL_EN:  fall_en_d  = wdata_w;
        ADDR_LEVEL:    level_d    = wdata_w;
        ADDR_DB_LIMIT: db_limit_d = writedata[DB_CNT_W-1:0];
        default:       ;
      endcase
    end

    // A new edge wins over a same-cycle clear so it is never lost
    set_w = (rise & rise_en_q) | (fall & fall_en_q);
    clr_w = (wr_en && address == ADDR_EDGE_CAP) ? wdata_w : '0;
    cap_d = set_w | (cap_q & ~clr_w);

    case (address)
      ADDR_DATA:     readdata_d = 32'(stable);
      ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
      ADDR_IRQ_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE_CAP: readdata_d = 32'(cap_q);
      ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
      ADDR_LEVEL:    readdata_d = 32'(level_q);
      ADDR_DB_LIMIT: readdata_d = 32'(db_limit_q);
      ADDR_RAW:      readdata_d = 32'(raw);
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en_q  <= WIDTH'(RISE_EN_RST);
      fall_en_q  <= WIDTH'(FALL_EN_RST);
      mask_q     <= '0;
      cap_q      <= '0;
      level_q    <= '0;
      db_limit_q <= '0;
      readdata_q <= '0;
    end else begin
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      level_q    <= level_d;
      db_limit_q <= db_limit_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(mask_q & ((level_q & stable) | (~level_q & cap_q)));

endmodule

// File: tb/tb_soc_system_pio_in_ext.sv
// Self-checking bench for soc_system_pio_in_ext: constant vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_soc_system_pio_in_ext;

  localparam int unsigned W    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DBW  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  addr = '0;
  logic        cs = 1'b0;
  logic        wr_n = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [W-1:0] inp = '0;

  int n_checks = 0;
  int n_errors = 0;

  soc_system_pio_in_ext #(.WIDTH(W), .SYNC_STAGES(SYNC), .DB_CNT_W(DBW)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (addr),
    .chipselect(cs),
    .write_n   (wr_n),
    .writedata (wdata),
    .readdata  (readdata),
    .irq       (irq),
    .in_port   (inp)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]   m_pipe [SYNC];
  logic [W-1:0]   m_stable, m_prev, m_cap, m_rise_en, m_fall_en, m_mask, m_level;
  int             m_run [W];
  logic [DBW-1:0] m_limit;
  logic [31:0]    m_rd;

  function automatic void model_reset();
    for (int j = 0; j < int'(SYNC); j++) m_pipe[j] = '0;
    for (int i = 0; i < int'(W); i++) m_run[i] = 0;
    m_stable = '0; m_prev = '0; m_cap = '0; m_mask = '0; m_level = '0;
    m_rise_en = '1; m_fall_en = '1; m_limit = '0; m_rd = '0;
  endfunction

  function automatic logic m_irq();
    return |(m_mask & ((m_level & m_stable) | (~m_level & m_cap)));
  endfunction

  // Advance the model by one clock using the inputs currently driven
  function automatic void model_step();
    logic [W-1:0] sync, n_stable, setv, clr;
    logic         wr;
    sync = m_pipe[SYNC-1];
    case (addr)
      3'd0: m_rd = 32'(m_stable);
      3'd1: m_rd = 32'(m_rise_en);
      3'd2: m_rd = 32'(m_mask);
      3'd3: m_rd = 32'(m_cap);
      3'd4: m_rd = 32'(m_fall_en);
      3'd5: m_rd = 32'(m_level);
      3'd6: m_rd = 32'(m_limit);
      default: m_rd = 32'(sync);
    endcase
    // A bit commits once it has disagreed with stable on m_limit samples in a row
    n_stable = m_stable;
    for (int i = 0; i < int'(W); i++) begin
      if (m_limit == 0) begin
        n_stable[i] = sync[i];
        m_run[i] = 0;
      end else if (sync[i] == m_stable[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= int'(m_limit)) begin
          n_stable[i] = sync[i];
          m_run[i] = 0;
        end
      end
    end
    setv  = (m_stable & ~m_prev & m_rise_en) | (~m_stable & m_prev & m_fall_en);
    wr    = cs && !wr_n;
    clr   = (wr && addr == 3'd3) ? wdata[W-1:0] : '0;
    m_cap = setv | (m_cap & ~clr);
    m_prev = m_stable;
    m_stable = n_stable;
    for (int j = int'(SYNC) - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
    m_pipe[0] = inp;
    if (wr) begin
      case (addr)
        3'd1: m_rise_en = wdata[W-1:0];
        3'd2: m_mask    = wdata[W-1:0];
        3'd4: m_fall_en = wdata[W-1:0];
        3'd5: m_level   = wdata[W-1:0];
        3'd6: m_limit   = wdata[DBW-1:0];
        default: ;
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_rd", readdata, m_rd);
    chk("model_irq", 32'(irq), 32'(m_irq()));
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    addr = a; cs = 1'b1; wr_n = 1'b0; wdata = d;
    tick();
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a);
    addr = a;
    tick();
  endtask

  task automatic do_reset();
    cs = 1'b0; wr_n = 1'b1; addr = '0; wdata = '0; inp = '0;
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [W-1:0] inp;
    int          cycles;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int lat;
    bit found;

    // Constant vectors from reset: DB_LIMIT = 0, any-edge capture
    tbl[0]  = '{3'd2, 1'b1, 32'hF, 4'h0, 1, 32'h0, 1'b0};
    tbl[1]  = '{3'd0, 1'b0, 32'h0, 4'h5, 3, 32'h0, 1'b0};
    tbl[2]  = '{3'd0, 1'b0, 32'h0, 4'h5, 1, 32'h5, 1'b1};
    tbl[3]  = '{3'd3, 1'b0, 32'h0, 4'h5, 1, 32'h5, 1'b1};
    tbl[4]  = '{3'd3, 1'b1, 32'h1, 4'h5, 1, 32'h5, 1'b1};
    tbl[5]  = '{3'd3, 1'b0, 32'h0, 4'h5, 1, 32'h4, 1'b1};
    tbl[6]  = '{3'd3, 1'b1, 32'hF, 4'h5, 1, 32'h4, 1'b0};
    tbl[7]  = '{3'd7, 1'b0, 32'h0, 4'h5, 1, 32'h5, 1'b0};
    tbl[8]  = '{3'd1, 1'b0, 32'h0, 4'h5, 1, 32'hF, 1'b0};
    tbl[9]  = '{3'd4, 1'b0, 32'h0, 4'h5, 1, 32'hF, 1'b0};
    tbl[10] = '{3'd6, 1'b0, 32'h0, 4'h5, 1, 32'h0, 1'b0};

    model_reset();
    #2;
    chk("reset_rd", readdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int r = 0; r < 11; r++) begin
      addr = tbl[r].addr; cs = tbl[r].we; wr_n = !tbl[r].we;
      wdata = tbl[r].wdata; inp = tbl[r].inp;
      repeat (tbl[r].cycles) tick();
      chk($sformatf("tbl%0d_rd", r), readdata, tbl[r].exp_rd);
      chk($sformatf("tbl%0d_irq", r), 32'(irq), 32'(tbl[r].exp_irq));
    end
    cs = 1'b0; wr_n = 1'b1;

    // Debounce: 9-cycle pulse is rejected, a held input commits after the limit
    do_reset();
    wr_reg(3'd6, 32'd10);
    addr = 3'd0;
    inp = 4'h1;
    repeat (9) tick();
    inp = 4'h0;
    repeat (15) tick();
    rd_reg(3'd0);
    chk("glitch_data", readdata, 32'h0);
    rd_reg(3'd3);
    chk("glitch_cap", readdata, 32'h0);
    addr = 3'd0;
    inp = 4'h1;
    lat = 0; found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      tick();
      if (readdata[0]) begin found = 1; lat = k; end
    end
    chk("db_latency", 32'(lat), 32'(SYNC + 10 + 1));
    rd_reg(3'd3);
    chk("db_cap", readdata, 32'h1);

    // Falling-only capture
    do_reset();
    wr_reg(3'd1, 32'h0);
    inp = 4'h1;
    repeat (8) tick();
    rd_reg(3'd3);
    chk("fall_only_rise", readdata, 32'h0);
    inp = 4'h0;
    repeat (8) tick();
    rd_reg(3'd3);
    chk("fall_only_fall", readdata, 32'h1);

    // Level IRQ source
    do_reset();
    wr_reg(3'd5, 32'h2);
    wr_reg(3'd2, 32'h2);
    inp = 4'h2;
    repeat (8) tick();
    chk("level_hi_irq", 32'(irq), 32'h1);
    inp = 4'h0;
    repeat (8) tick();
    chk("level_lo_irq", 32'(irq), 32'h0);
    wr_reg(3'd5, 32'h0);
    chk("edge_src_irq", 32'(irq), 32'h1);

    // W1C colliding with a new rise keeps the capture
    do_reset();
    addr = 3'd0;
    inp = 4'h1;
    repeat (3) tick();
    wr_reg(3'd3, 32'h1);
    rd_reg(3'd3);
    chk("w1c_vs_set", readdata, 32'h1);

    // Asynchronous reset in the middle of a debounce count
    do_reset();
    wr_reg(3'd2, 32'hF);
    wr_reg(3'd6, 32'd10);
    addr = 3'd0;
    inp = 4'hF;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_rd", readdata, 32'h0);
    chk("mid_reset_irq", 32'(irq), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    lat = 0; found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      tick();
      if (readdata == 32'hF) begin found = 1; lat = k; end
    end
    chk("post_reset_latency", 32'(lat), 32'(SYNC + 2));
    rd_reg(3'd1);
    chk("post_reset_rise_en", readdata, 32'hF);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(W); i++)
        if ($urandom_range(0, 7) == 0) inp[i] = ~inp[i];
      addr = 3'($urandom_range(0, 7));
      cs = 1'($urandom_range(0, 1));
      wr_n = ($urandom_range(0, 3) != 0);
      wdata = (addr == 3'd6) ? 32'($urandom_range(0, 6)) : $urandom;
      tick();
    end
    cs = 1'b0; wr_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
